// File: rtl/i2c_regfile_target.sv
// I2C target exposing NUM_CTRL R/W control bytes and NUM_STAT read-only status bytes behind an auto-incrementing pointer.
// Latency: pad to bus event is 2+FILT_LEN I_clk cycles; register writes and strobes land on the 8th filtered SCL rise.
// Backpressure: none; the target never stretches SCL and always ACKs pointer and data bytes once addressed.
module i2c_regfile_target #(
  parameter int                    ADDR_LSB_W = 4,
  parameter logic [6-ADDR_LSB_W:0] ADDR_HI    = 3'b010,
  parameter int                    NUM_CTRL   = 4,
  parameter int                    NUM_STAT   = 4,
  parameter int                    FILT_LEN   = 3,
  parameter logic [7:0]            CREG_RST   = 8'h00
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic                    I_scl,
  input  logic                    I_sda,
  output logic                    O_sda_oe,
  input  logic [ADDR_LSB_W-1:0]   I_myaddr,
  output logic [8*NUM_CTRL-1:0]   O_creg,
  input  logic [8*NUM_STAT-1:0]   I_stat,
  output logic [NUM_CTRL-1:0]     O_wr_strb,
  output logic [NUM_STAT-1:0]     O_rd_strb,
  output logic                    O_started,
  output logic                    O_sel
);

  localparam int         FCW      = $clog2(FILT_LEN + 1);
  localparam logic [7:0] PTR_LAST = 8'(NUM_CTRL + NUM_STAT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_A_ACK, S_PTR, S_P_ACK, S_WR, S_W_ACK, S_RD, S_M_ACK
  } state_t;

  // index 0 carries SCL, index 1 carries SDA through the input path
  logic [1:0]     sync1_q, sync2_q, filt_q, filt_d, prev_q;
  logic [FCW-1:0] fcnt_q [2];
  logic [FCW-1:0] fcnt_d [2];

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      sh_q, sh_d;
  logic [7:0]      ptr_q, ptr_d, ptr_inc;
  logic [7:0]      creg_q [NUM_CTRL];
  logic [7:0]      creg_d [NUM_CTRL];
  logic            oe_q, oe_d, sel_q, sel_d, started_q, started_d, rw_q, rw_d;
  logic [NUM_CTRL-1:0] wr_strb_q, wr_strb_d;
  logic [NUM_STAT-1:0] rd_strb_q, rd_strb_d, rd_hit;
  logic [7:0]      rd_byte;
  logic            scl_rise, scl_fall, start_det, stop_det, do_load;

  // Level filter: a filtered line flips only after FILT_LEN consecutive samples disagree with it
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCW'(FILT_LEN - 1)) filt_d[i] = sync2_q[i];
        else                                  fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  assign scl_rise  =  filt_q[0] & ~prev_q[0];
  assign scl_fall  = ~filt_q[0] &  prev_q[0];
  assign start_det =  prev_q[1] & ~filt_q[1] & filt_q[0] & prev_q[0];
  assign stop_det  = ~prev_q[1] &  filt_q[1] & filt_q[0] & prev_q[0];
  assign ptr_inc   = (ptr_q >= PTR_LAST) ? 8'd0 : ptr_q + 8'd1;

  // Read-side mux: control byte, live status byte, or 0xFF past the end of the map
  always_comb begin
    rd_byte = 8'hFF;
    rd_hit  = '0;
    for (int k = 0; k < NUM_CTRL; k++)
      if (ptr_q == 8'(k)) rd_byte = creg_q[k];
    for (int k = 0; k < NUM_STAT; k++)
      if (ptr_q == 8'(NUM_CTRL + k)) begin
        rd_byte   = I_stat[8*k +: 8];
        rd_hit[k] = 1'b1;
      end
  end

  // Protocol FSM: START/STOP override everything, otherwise act on filtered SCL edges
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    creg_d    = creg_q;
    oe_d      = oe_q;
    sel_d     = sel_q;
    started_d = started_q;
    rw_d      = rw_q;
    wr_strb_d = '0;
    rd_strb_d = '0;
    do_load   = 1'b0;
    if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      sel_d     = 1'b0;
      started_d = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      sel_d     = 1'b0;
      started_d = 1'b1;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WR: begin
          if (scl_rise) begin
            sh_d = {sh_q[5:0], filt_q[1]};
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == S_ADDR) begin
                if (sh_q == {ADDR_HI, I_myaddr}) begin
                  state_d = S_A_ACK;
                  sel_d   = 1'b1;
                  rw_d    = filt_q[1];
                end else begin
                  state_d = S_IDLE;
                end
              end else if (state_q == S_PTR) begin
                ptr_d   = {sh_q, filt_q[1]};
                state_d = S_P_ACK;
              end else begin
                for (int k = 0; k < NUM_CTRL; k++)
                  if (ptr_q == 8'(k)) begin
                    creg_d[k]    = {sh_q, filt_q[1]};
                    wr_strb_d[k] = 1'b1;
                  end
                ptr_d   = ptr_inc;
                state_d = S_W_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // first falling edge starts the ACK drive, the second one ends it
        S_A_ACK, S_P_ACK, S_W_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d = 1'b0;
              if (state_q == S_A_ACK && rw_q) do_load = 1'b1;
              else if (state_q == S_A_ACK)    state_d = S_PTR;
              else                            state_d = S_WR;
            end
          end
        end
        S_RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = S_M_ACK;
              bit_cnt_d = '0;
              oe_d      = 1'b0;
            end else begin
              oe_d = ~sh_q[6];
              sh_d = {sh_q[5:0], 1'b1};
            end
          end
        end
        // controller ACK keeps the read going; NACK parks in IDLE until STOP or Sr
        S_M_ACK: begin
          if (scl_rise) begin
            if (filt_q[1]) begin
              state_d = S_IDLE;
              sel_d   = 1'b0;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            do_load = 1'b1;
          end
        end
        default: ;
      endcase
      if (do_load) begin
        state_d   = S_RD;
        bit_cnt_d = '0;
        sh_d      = rd_byte[6:0];
        oe_d      = ~rd_byte[7];
        rd_strb_d = rd_hit;
        ptr_d     = ptr_inc;
      end
    end
  end

  // State registers; bus lines reset to their idle-high level
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      prev_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      for (int k = 0; k < NUM_CTRL; k++) creg_q[k] <= CREG_RST;
      oe_q      <= 1'b0;
      sel_q     <= 1'b0;
      started_q <= 1'b0;
      rw_q      <= 1'b0;
      wr_strb_q <= '0;
      rd_strb_q <= '0;
    end else begin
      sync1_q   <= {I_sda, I_scl};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      prev_q    <= filt_q;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      creg_q    <= creg_d;
      oe_q      <= oe_d;
      sel_q     <= sel_d;
      started_q <= started_d;
      rw_q      <= rw_d;
      wr_strb_q <= wr_strb_d;
      rd_strb_q <= rd_strb_d;
    end
  end

  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_creg
    assign O_creg[8*k +: 8] = creg_q[k];
  end

  assign O_sda_oe  = oe_q;
  assign O_wr_strb = wr_strb_q;
  assign O_rd_strb = rd_strb_q;
  assign O_started = started_q;
  assign O_sel     = sel_q;

endmodule

// File: tb/tb_i2c_regfile_target.sv
// Directed bench: drives I2C controller waveforms on an open-drain bus model and checks against hand-computed values.
// Latency: one SCL quarter period is Q system clocks, well above the 2+FILT_LEN input delay.
// Backpressure: not applicable; strobe pulses are tallied every cycle by a monitor.
module tb_i2c_regfile_target;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_drv = 1'b1;
  logic        sda_drv = 1'b1;
  logic        glitch = 1'b0;
  logic        sda_line;
  logic        sda_oe;
  logic [3:0]  myaddr = 4'h2;
  logic [31:0] creg;
  logic [31:0] stat = 32'h1122_3344;
  logic [3:0]  wr_strb, rd_strb;
  logic        started, sel;

  int total = 0;
  int bad = 0;
  int wr_cnt [4] = '{0, 0, 0, 0};
  int rd_cnt [4] = '{0, 0, 0, 0};

  assign sda_line = (sda_drv ^ glitch) & ~sda_oe;

  always #5 clk = ~clk;

  i2c_regfile_target dut (
    .I_clk     (clk),
    .I_rst_n   (rst_n),
    .I_scl     (scl_drv),
    .I_sda     (sda_line),
    .O_sda_oe  (sda_oe),
    .I_myaddr  (myaddr),
    .O_creg    (creg),
    .I_stat    (stat),
    .O_wr_strb (wr_strb),
    .O_rd_strb (rd_strb),
    .O_started (started),
    .O_sel     (sel)
  );

  // Tally strobe-high cycles; a correct strobe contributes exactly one per event
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_strb[k]) wr_cnt[k] = wr_cnt[k] + 1;
      if (rd_strb[k]) rd_cnt[k] = rd_cnt[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic qw(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    qw(2); sda_drv = 1'b1; qw(Q);
    scl_drv = 1'b1; qw(Q);
    sda_drv = 1'b0; qw(Q);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    qw(2); sda_drv = 1'b0; qw(Q);
    scl_drv = 1'b1; qw(Q);
    sda_drv = 1'b1; qw(Q);
  endtask

  // gbit >= 0 injects a one-cycle SDA inversion while SCL is high on that bit
  task automatic wbyte(input logic [7:0] b, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      qw(2); sda_drv = b[i]; qw(Q - 2);
      scl_drv = 1'b1;
      if (i == gbit) begin
        qw(5); glitch = 1'b1; qw(1); glitch = 1'b0; qw(2*Q - 6);
      end else begin
        qw(2*Q);
      end
      scl_drv = 1'b0;
    end
    qw(2); sda_drv = 1'b1; qw(Q - 2);
    scl_drv = 1'b1; qw(Q);
    ack = sda_line; qw(Q);
    scl_drv = 1'b0;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] b);
    qw(2); sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      qw(Q); scl_drv = 1'b1;
      qw(Q); b[i] = sda_line;
      qw(Q); scl_drv = 1'b0;
    end
    qw(2); sda_drv = nack; qw(Q - 2);
    scl_drv = 1'b1; qw(2*Q);
    scl_drv = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [3:0] acks;
    logic [7:0] rd0, rd1;
    int         w0, w1, w2, w3, r0, r1, r2;

    // reset state
    qw(3);
    check("rst_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_creg", creg, 32'h0);
    check("rst_strb", {24'd0, rd_strb, wr_strb}, 32'd0);
    check("rst_started_sel", {30'd0, started, sel}, 32'd0);
    rst_n = 1'b1;
    qw(5);

    // write pointer 1 then 0xA5, 0x3C
    w0 = wr_cnt[0]; w1 = wr_cnt[1]; w2 = wr_cnt[2];
    i2c_start();
    wbyte(8'h44, -1, acks[3]);
    check("t1_sel", {31'd0, sel}, 32'd1);
    check("t1_started", {31'd0, started}, 32'd1);
    wbyte(8'h01, -1, acks[2]);
    wbyte(8'hA5, -1, acks[1]);
    wbyte(8'h3C, -1, acks[0]);
    i2c_stop();
    check("t1_acks", {28'd0, acks}, 32'd0);
    check("t1_creg", creg, 32'h003C_A500);
    check("t1_wr_strb", {8'd0, 8'(wr_cnt[0] - w0), 8'(wr_cnt[1] - w1), 8'(wr_cnt[2] - w2)}, 32'h0000_0101);
    check("t1_idle", {30'd0, started, sel}, 32'd0);

    // pointer 4, repeated start, read status bytes 0 and 1
    r0 = rd_cnt[0]; r1 = rd_cnt[1]; r2 = rd_cnt[2];
    i2c_start();
    wbyte(8'h44, -1, acks[3]);
    wbyte(8'h04, -1, acks[2]);
    i2c_start();
    wbyte(8'h45, -1, acks[1]);
    check("t2_acks", {29'd0, acks[3:1]}, 32'd0);
    rbyte(1'b0, rd0);
    rbyte(1'b1, rd1);
    qw(Q);
    check("t2_rd0", {24'd0, rd0}, 32'h44);
    check("t2_rd1", {24'd0, rd1}, 32'h33);
    check("t2_oe_after_nack", {31'd0, sda_oe}, 32'd0);
    check("t2_rd_strb", {8'd0, 8'(rd_cnt[0] - r0), 8'(rd_cnt[1] - r1), 8'(rd_cnt[2] - r2)}, 32'h0001_0100);
    i2c_stop();

    // wrong address is ignored, then a normal write to ctrl 0
    i2c_start();
    wbyte(8'h46, -1, acks[3]);
    check("t3_sel", {31'd0, sel}, 32'd0);
    wbyte(8'h02, -1, acks[2]);
    wbyte(8'h77, -1, acks[1]);
    i2c_stop();
    check("t3_nacks", {29'd0, acks[3:1]}, 32'd7);
    check("t3_creg_kept", creg, 32'h003C_A500);
    i2c_start();
    wbyte(8'h44, -1, acks[3]);
    wbyte(8'h00, -1, acks[2]);
    wbyte(8'h5A, -1, acks[1]);
    i2c_stop();
    check("t3_acks", {29'd0, acks[3:1]}, 32'd0);
    check("t3_creg", creg, 32'h003C_A55A);

    // pointer 7: first byte discarded, pointer wraps to ctrl 0
    w0 = wr_cnt[0]; w1 = wr_cnt[1]; w2 = wr_cnt[2]; w3 = wr_cnt[3];
    i2c_start();
    wbyte(8'h44, -1, acks[3]);
    wbyte(8'h07, -1, acks[2]);
    wbyte(8'hEE, -1, acks[1]);
    wbyte(8'h96, -1, acks[0]);
    i2c_stop();
    check("t4_acks", {28'd0, acks}, 32'd0);
    check("t4_creg", creg, 32'h003C_A596);
    check("t4_wr_strb", {8'(wr_cnt[3] - w3), 8'(wr_cnt[2] - w2), 8'(wr_cnt[1] - w1), 8'(wr_cnt[0] - w0)}, 32'h0000_0001);

    // one-cycle glitches that look like START and STOP must be filtered out
    i2c_start();
    wbyte(8'h44, -1, acks[3]);
    wbyte(8'h02, -1, acks[2]);
    wbyte(8'h81, 7, acks[1]);
    wbyte(8'h7E, 0, acks[0]);
    check("t5_started", {31'd0, started}, 32'd1);
    i2c_stop();
    check("t5_acks", {28'd0, acks}, 32'd0);
    check("t5_creg", creg, 32'h7E81_A596);

    // reset while the target is driving bit 7 (=0) of creg[3]
    i2c_start();
    wbyte(8'h44, -1, acks[3]);
    wbyte(8'h03, -1, acks[2]);
    i2c_start();
    wbyte(8'h45, -1, acks[1]);
    qw(Q);
    check("t6_driving", {31'd0, sda_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("t6_rst_oe", {31'd0, sda_oe}, 32'd0);
    check("t6_rst_creg", creg, 32'h0);
    check("t6_rst_sel", {30'd0, started, sel}, 32'd0);
    qw(2);
    rst_n = 1'b1;
    qw(3);
    // bus traffic without a START is ignored
    wbyte(8'h44, -1, ack);
    check("t6_no_start_nack", {31'd0, ack}, 32'd1);
    check("t6_no_start_sel", {31'd0, sel}, 32'd0);
    i2c_stop();
    i2c_start();
    wbyte(8'h44, -1, ack);
    check("t6_recover_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    check("t6_end_idle", {30'd0, started, sel}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
